// File: rtl/mem_stage_rsp.sv
// mem_stage_rsp: MEM pipeline stage that waits for data responses, buffers them across WB stalls and drops responses owed to flushed loads (optional lwl/lwr merge under MS_LWLR_EN)
module mem_stage_rsp #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             es_to_ms_valid,
  output logic             ms_allowin,
  input  logic             es_req_sent,
  input  logic [2:0]       es_load_op,
  input  logic [31:0]      es_exe_result,
  input  logic [4:0]       es_dest,
  input  logic             es_gr_we,
  input  logic [31:0]      es_pc,
  input  logic             data_data_ok,
  input  logic [31:0]      data_rdata,
  input  logic             ws_allowin,
  output logic             ms_to_ws_valid,
  output logic [4:0]       ms_dest,
  output logic [31:0]      ms_result,
  output logic [3:0]       ms_gr_strb,
  output logic [31:0]      ms_pc,
  input  logic             flush,
  output logic [3:0]       ms_fwd_strb,
  output logic             ms_fwd_pending,
  output logic [CNT_W-1:0] ms_cancel_cnt
);
  logic             ms_valid, req_sent, gr_we, rsp_buf_valid;
  logic [2:0]       load_op;
  logic [31:0]      exe_result, rsp_buf_data, word;
  logic [CNT_W-1:0] cancel_cnt;
  logic             ms_ready_go, cnt_full, rsp_hit, inc, dec, capture, leave;
  logic [1:0]       addr;
  logic [7:0]       bte;
  logic [15:0]      hlf;

  assign cnt_full       = cancel_cnt == CNT_W'(MAX_OUTSTANDING);
  assign rsp_hit        = data_data_ok && cancel_cnt == '0;
  assign ms_ready_go    = !req_sent || rsp_buf_valid || rsp_hit;
  assign ms_allowin     = (!ms_valid || (ms_ready_go && ws_allowin)) && !cnt_full;
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
  assign leave          = flush || (ms_valid && ms_ready_go && ws_allowin);
  assign capture        = ms_valid && req_sent && rsp_hit && !ws_allowin && !rsp_buf_valid && !flush;
  assign inc            = flush && ms_valid && !ms_ready_go && !cnt_full;
  assign dec            = data_data_ok && cancel_cnt != '0;
  assign ms_fwd_strb    = {4{ms_valid && ms_ready_go}} & ms_gr_strb;
  assign ms_fwd_pending = ms_valid && gr_we && !ms_ready_go;
  assign ms_cancel_cnt  = cancel_cnt;
  assign word           = rsp_buf_valid ? rsp_buf_data : data_rdata;
  assign addr           = exe_result[1:0];
  assign bte            = word[{addr, 3'b000} +: 8];
  assign hlf            = addr[1] ? word[31:16] : word[15:0];

  // Pipeline register: flush empties the stage and blocks entry in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid   <= 1'b0;
      req_sent   <= 1'b0;
      load_op    <= '0;
      exe_result <= '0;
      ms_dest    <= '0;
      gr_we      <= 1'b0;
      ms_pc      <= '0;
    end else begin
      if (flush) ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid && ms_allowin && !flush) begin
        req_sent   <= es_req_sent;
        load_op    <= es_load_op;
        exe_result <= es_exe_result;
        ms_dest    <= es_dest;
        gr_we      <= es_gr_we;
        ms_pc      <= es_pc;
      end
    end
  end

  // Hold a response that arrived while WB was stalled until the instruction leaves
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_buf_valid <= 1'b0;
      rsp_buf_data  <= '0;
    end else if (leave) begin
      rsp_buf_valid <= 1'b0;
    end else if (capture) begin
      rsp_buf_valid <= 1'b1;
      rsp_buf_data  <= data_rdata;
    end
  end

  // Count responses still owed to flushed loads; each one arriving later is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cancel_cnt <= '0;
    else if (inc && !dec) cancel_cnt <= cancel_cnt + CNT_W'(1);
    else if (dec && !inc) cancel_cnt <= cancel_cnt - CNT_W'(1);
  end

  // Load data extraction and register write strobes
  always_comb begin
    ms_result  = exe_result;
    ms_gr_strb = {4{gr_we}};
    case (load_op)
      3'd1: ms_result = {{24{bte[7]}}, bte};
      3'd2: ms_result = {24'd0, bte};
      3'd3: ms_result = {{16{hlf[15]}}, hlf};
      3'd4: ms_result = {16'd0, hlf};
      3'd5: ms_result = word;
`ifdef MS_LWLR_EN
      3'd6: begin
        ms_result  = word << {~addr, 3'b000};
        ms_gr_strb = 4'b1111 << ~addr;
      end
      3'd7: begin
        ms_result  = word >> {addr, 3'b000};
        ms_gr_strb = 4'b1111 >> addr;
      end
`else
      3'd6, 3'd7: begin
        ms_result  = word;
        ms_gr_strb = 4'b0000;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_stage_rsp.sv
// tb_mem_stage_rsp: table-driven and scoreboard checks for mem_stage_rsp
module tb_mem_stage_rsp;
  logic        clk = 1'b0, reset = 1'b1;
  logic        es_to_ms_valid = 1'b0, es_req_sent = 1'b0, es_gr_we = 1'b0;
  logic [2:0]  es_load_op = '0;
  logic [31:0] es_exe_result = '0, es_pc = '0, data_rdata = '0;
  logic [4:0]  es_dest = '0;
  logic        data_data_ok = 1'b0, ws_allowin = 1'b1, flush = 1'b0;
  logic        ms_allowin, ms_to_ws_valid, ms_fwd_pending;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result, ms_pc;
  logic [3:0]  ms_gr_strb, ms_fwd_strb;
  logic [2:0]  ms_cancel_cnt;

  mem_stage_rsp dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_req_sent(es_req_sent), .es_load_op(es_load_op), .es_exe_result(es_exe_result),
    .es_dest(es_dest), .es_gr_we(es_gr_we), .es_pc(es_pc), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_dest(ms_dest), .ms_result(ms_result), .ms_gr_strb(ms_gr_strb), .ms_pc(ms_pc),
    .flush(flush), .ms_fwd_strb(ms_fwd_strb), .ms_fwd_pending(ms_fwd_pending),
    .ms_cancel_cnt(ms_cancel_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        rs;
    logic [31:0] res;
    logic [3:0]  strb;
  } vec_t;
  typedef struct {
    logic [31:0] res;
    logic [3:0]  strb;
    logic [4:0]  dest;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  vec_t v[14];
  int checks = 0, passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic rs,
                       input logic [4:0] d, input logic [31:0] p);
    es_to_ms_valid = 1'b1; es_load_op = op; es_exe_result = addr; es_req_sent = rs;
    es_dest = d; es_gr_we = 1'b1; es_pc = p;
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
  endtask

  task automatic flush_one(input logic [31:0] p);
    issue(3'd5, 32'h0, 1'b1, 5'd9, p);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // Retired instructions are compared in order against the scoreboard
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_retire: pc %h with empty scoreboard", ms_pc);
      end else begin
        e = sb.pop_front();
        chk("result", ms_result, e.res);
        chk("gr_strb", 32'(ms_gr_strb), 32'(e.strb));
        chk("dest", 32'(ms_dest), 32'(e.dest));
        chk("pc", ms_pc, e.pc);
      end
    end
  end

  initial begin
    v[0]  = '{3'd0, 32'h1234_5678, 32'h0,         1'b0, 32'h1234_5678, 4'b1111};
    v[1]  = '{3'd1, 32'd3,         32'h80FF_FF12, 1'b1, 32'hFFFF_FF80, 4'b1111};
    v[2]  = '{3'd1, 32'd0,         32'h8765_43A1, 1'b1, 32'hFFFF_FFA1, 4'b1111};
    v[3]  = '{3'd2, 32'd0,         32'h8765_43A1, 1'b1, 32'h0000_00A1, 4'b1111};
    v[4]  = '{3'd1, 32'd1,         32'h8765_43A1, 1'b1, 32'h0000_0043, 4'b1111};
    v[5]  = '{3'd3, 32'd2,         32'h8765_43A1, 1'b1, 32'hFFFF_8765, 4'b1111};
    v[6]  = '{3'd4, 32'd2,         32'h8765_43A1, 1'b1, 32'h0000_8765, 4'b1111};
    v[7]  = '{3'd5, 32'd0,         32'h8765_43A1, 1'b1, 32'h8765_43A1, 4'b1111};
    v[12] = '{3'd2, 32'd3,         32'h80FF_FF12, 1'b1, 32'h0000_0080, 4'b1111};
    v[13] = '{3'd3, 32'd0,         32'h0000_8001, 1'b1, 32'hFFFF_8001, 4'b1111};
`ifdef MS_LWLR_EN
    v[8]  = '{3'd6, 32'd1,         32'h1122_3344, 1'b1, 32'h3344_0000, 4'b1100};
    v[9]  = '{3'd7, 32'd2,         32'h8765_43A1, 1'b1, 32'h0000_8765, 4'b0011};
    v[10] = '{3'd6, 32'd0,         32'h8765_43A1, 1'b1, 32'hA100_0000, 4'b1000};
    v[11] = '{3'd7, 32'd3,         32'h8765_43A1, 1'b1, 32'h0000_0087, 4'b0001};
`else
    v[8]  = '{3'd6, 32'd1,         32'h1122_3344, 1'b1, 32'h1122_3344, 4'b0000};
    v[9]  = '{3'd7, 32'd2,         32'h8765_43A1, 1'b1, 32'h8765_43A1, 4'b0000};
    v[10] = '{3'd6, 32'd0,         32'h8765_43A1, 1'b1, 32'h8765_43A1, 4'b0000};
    v[11] = '{3'd7, 32'd3,         32'h8765_43A1, 1'b1, 32'h8765_43A1, 4'b0000};
`endif
    @(negedge clk);
    chk("rst_allowin", 32'(ms_allowin), 32'd1);
    chk("rst_valid", 32'(ms_to_ws_valid), 32'd0);
    chk("rst_result", ms_result, 32'd0);
    chk("rst_pc_dest", {ms_pc[26:0], ms_dest}, 32'd0);
    chk("rst_strbs", 32'({ms_gr_strb, ms_fwd_strb, ms_fwd_pending}), 32'd0);
    chk("rst_cnt", 32'(ms_cancel_cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      sb.push_back('{v[i].res, v[i].strb, 5'(i + 1), 32'h1000 + 32'(i) * 4});
      issue(v[i].op, v[i].addr, v[i].rs, 5'(i + 1), 32'h1000 + 32'(i) * 4);
      data_data_ok = v[i].rs; data_rdata = v[i].rdata;
      @(negedge clk);
      chk("lat1_valid", 32'(ms_to_ws_valid), 32'd1);
      @(posedge clk); #1;
      data_data_ok = 1'b0;
    end
    sb.push_back('{32'hCAFE_F00D, 4'b1111, 5'd20, 32'h2000});
    issue(3'd5, 32'h0, 1'b1, 5'd20, 32'h2000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("late_valid", 32'(ms_to_ws_valid), 32'd0);
      chk("late_pending", 32'(ms_fwd_pending), 32'd1);
      @(posedge clk); #1;
    end
    data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("late_arrive_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("late_arrive_fwd", 32'({ms_fwd_pending, ms_fwd_strb}), 32'b01111);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    ws_allowin = 1'b0;
    sb.push_back('{32'h0BAD_BEEF, 4'b1111, 5'd21, 32'h2004});
    issue(3'd5, 32'h0, 1'b1, 5'd21, 32'h2004);
    data_data_ok = 1'b1; data_rdata = 32'h0BAD_BEEF;
    @(negedge clk);
    chk("stall_allowin", 32'(ms_allowin), 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b0; data_rdata = 32'hDEAD_DEAD;
    @(negedge clk);
    chk("stall_buf_result", ms_result, 32'h0BAD_BEEF);
    chk("stall_buf_valid", 32'(ms_to_ws_valid), 32'd1);
    @(posedge clk); #1;
    ws_allowin = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_drained", 32'(ms_to_ws_valid), 32'd0);
    issue(3'd5, 32'h0, 1'b1, 5'd22, 32'h2008);
    @(negedge clk);
    chk("flush_pending", 32'(ms_fwd_pending), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_valid", 32'(ms_to_ws_valid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_cnt1", 32'(ms_cancel_cnt), 32'd1);
    @(posedge clk); #1;
    data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("drop_valid", 32'(ms_to_ws_valid), 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("drop_cnt0", 32'(ms_cancel_cnt), 32'd0);
    sb.push_back('{32'h1234_5678, 4'b1111, 5'd23, 32'h200C});
    issue(3'd5, 32'h0, 1'b1, 5'd23, 32'h200C);
    data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("second_lw_valid", 32'(ms_to_ws_valid), 32'd1);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    flush_one(32'h2010);
    sb.push_back('{32'h7777_0001, 4'b1111, 5'd24, 32'h2014});
    issue(3'd5, 32'h0, 1'b1, 5'd24, 32'h2014);
    data_data_ok = 1'b1; data_rdata = 32'h6666_0000;
    @(negedge clk);
    chk("stale_ok_valid", 32'(ms_to_ws_valid), 32'd0);
    chk("stale_ok_pending", 32'(ms_fwd_pending), 32'd1);
    @(posedge clk); #1;
    data_rdata = 32'h7777_0001;
    @(negedge clk);
    chk("own_ok_cnt", 32'(ms_cancel_cnt), 32'd0);
    chk("own_ok_valid", 32'(ms_to_ws_valid), 32'd1);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    issue(3'd5, 32'h0, 1'b1, 5'd25, 32'h2018);
    flush = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h4444_4444;
    @(negedge clk);
    chk("flush_ok_valid", 32'(ms_to_ws_valid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; data_data_ok = 1'b0;
    @(negedge clk);
    chk("flush_ok_cnt", 32'(ms_cancel_cnt), 32'd0);
    chk("flush_ok_pending", 32'(ms_fwd_pending), 32'd0);
    flush_one(32'h2020);
    issue(3'd5, 32'h0, 1'b1, 5'd26, 32'h2024);
    flush = 1'b1; data_data_ok = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; data_data_ok = 1'b0;
    @(negedge clk);
    chk("incdec_cnt", 32'(ms_cancel_cnt), 32'd1);
    flush_one(32'h2028);
    @(negedge clk);
    chk("sat_cnt", 32'(ms_cancel_cnt), 32'd2);
    chk("sat_allowin", 32'(ms_allowin), 32'd0);
    issue(3'd0, 32'h9999_9999, 1'b0, 5'd27, 32'h202C);
    @(negedge clk);
    chk("sat_blocked", 32'(ms_to_ws_valid), 32'd0);
    data_data_ok = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("sat_drain_cnt", 32'(ms_cancel_cnt), 32'd0);
    chk("sat_drain_allowin", 32'(ms_allowin), 32'd1);
    flush_one(32'h2030);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(ms_cancel_cnt), 32'd0);
    chk("async_rst_allowin", 32'(ms_allowin), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; data_data_ok = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(ms_to_ws_valid), 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("post_rst_cnt", 32'(ms_cancel_cnt), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
